spinner_quad_emu: RTL and testbench
===================================

# spinner_quad_emu

Emulates the arcade spinner's 2-bit quadrature encoder from PS/2 mouse X deltas and D-pad left/right. It sits directly upstream of the Arkanoid core's `spinner[1:0]` input, in place of ad-hoc encoder logic in the top level. A signed position accumulator holds pending motion. A fixed-rate stepper drains it one count per step tick, emitting one Gray-code transition per count.

## Interface
Parameters:
- `CLK_DIV`, 8: clock-enable prescaler; 48 MHz / 8 = 6 MHz `ce`.
- `STEP_DIV`, 1500: `ce` ticks per encoder step (4 kHz).
- `POLL_TICKS`, 48000: `ce` ticks between D-pad reloads (8 ms).
- `SLOW_STEP`, 4: D-pad counts per reload.
- `FAST_STEP`, 9: D-pad counts per reload while `dpad_fast` is high.
- `POS_W`, 12: accumulator width, two's complement.

Ports:
- `clk_48m` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `mouse_strobe` in 1: one-cycle pulse; `mouse_x` valid.
- `mouse_x` in 9: signed X delta (bit 8 = sign).
- `dpad_left` in 1: active-high.
- `dpad_right` in 1: active-high.
- `dpad_fast` in 1: selects `FAST_STEP`.
- `spinner` out 2: quadrature output to the core.
- `busy` out 1: high while position ≠ 0.
- `position` out `POS_W`: accumulator, for debug.

## Operation
- `ce` is asserted for one cycle when the prescaler equals 0. The prescaler wraps at `CLK_DIV-1`.
- On `ce`, the step divider increments and wraps at `STEP_DIV-1`. `step_tick` = `ce` and divider == 0.
- **Step, position < 0:**
  - `spinner` advances 00→01→11→10→00.
  - position += 1.
- **Step, position > 0:**
  - `spinner` advances 00→10→11→01→00.
  - position −= 1.
- **Step, position == 0:** no change to `spinner` or position.
- **Mouse strobe:** sum = position + sign-extend(`mouse_x`).
  - Sum is taken if the signs of position and `mouse_x` differ, or if sum has the same sign as position.
  - Otherwise position saturates to 0x7FF when positive, 0x800 when negative.
- **D-pad:**
  - While `dpad_left` or `dpad_right` is high, `poll_cnt` counts `ce` ticks.
  - At `POLL_TICKS`, position is overwritten (not added) with ±`SLOW_STEP` or ±`FAST_STEP`, and `poll_cnt` clears.
  - `dpad_right` wins when both are held: positive load.
  - With both released, `poll_cnt` holds 0.
- **Priority within one cycle:** D-pad load > mouse strobe > step.
  - A strobe coincident with a D-pad load is dropped.
  - A step tick coincident with a strobe or load is recorded in `step_pend`. It executes on the next cycle using the updated position, then `step_pend` clears.
  - `step_pend` is only set on `step_tick`, so at most one step is ever pending.
- `busy` = (position ≠ 0), registered alongside position.

## Timing
- Reset values: `spinner`=00, `position`=0, `busy`=0, prescaler=0, step divider=0, `poll_cnt`=0, `step_pend`=0.
- Mouse strobe at cycle t → `position` updated at t+1.
- First `spinner` edge occurs at the next `step_tick`. N counts drain in N step ticks (250 µs each).
- A deferred step executes exactly 1 cycle after its tick.
- Reset asserted mid-drain: all state returns to reset values immediately. Pending motion is discarded. After release, counting starts from prescaler 0.
- Saturation never wraps the accumulator sign.

## Configuration
- `SPINNER_DPAD_EN` defined:
  - D-pad reload logic and `poll_cnt` are compiled in.
- `SPINNER_DPAD_EN` undefined:
  - `dpad_*` inputs are ignored and `poll_cnt` is absent.
  - Position changes only via mouse strobe and steps.
  - Priority reduces to strobe > step.

## Test plan
- **Reset then idle 10,000 cycles** → `spinner`=00, `busy`=0, `position`=0.
- **Strobe `mouse_x`=+3** → `position`=3 next cycle. Next three step ticks give `spinner` 10, 11, 01 and `position` 2, 1, 0. `busy` falls with `position`=0. No further edges.
- **Strobe `mouse_x`=−2 (0x1FE)** → `spinner` 01, 11. `position` −1, then 0.
- **Saturation:**
  - Preload `position`=0x7F0 via strobes, then strobe +0xFF → `position`=0x7FF.
  - Preload `position`=0x800, then strobe −1 → stays 0x800.
  - Preload `position`=0x7FF, then strobe −5 → 0x7FA.
- **D-pad (with `SPINNER_DPAD_EN`):**
  - `dpad_right`+`dpad_fast` held → `position`=9 after 48,000 `ce` (384,000 clocks).
  - `dpad_left` alone → −4.
  - Both held → +4.
  - Strobe coincident with a reload → strobe dropped.
- **Coincidence and reset:**
  - Strobe +5 on a `step_tick` cycle with `position`=2 → `position`=7, then 6 one cycle later. `spinner` advances once.
  - Assert `reset` mid-drain → all outputs 0 asynchronously.

Source files
------------

// File: rtl/spinner_quad_emu.sv
// Arcade spinner quadrature emulator: mouse X deltas and D-pad accumulate into a
// signed position that a fixed-rate stepper drains as Gray-code steps. D-pad reload: SPINNER_DPAD_EN.
`timescale 1ns/1ps
module spinner_quad_emu #(
  parameter int CLK_DIV    = 8,
  parameter int STEP_DIV   = 1500,
  parameter int POLL_TICKS = 48000,
  parameter int SLOW_STEP  = 4,
  parameter int FAST_STEP  = 9,
  parameter int POS_W      = 12
) (
  input  logic             clk_48m,
  input  logic             reset,
  input  logic             mouse_strobe,
  input  logic [8:0]       mouse_x,
  input  logic             dpad_left,
  input  logic             dpad_right,
  input  logic             dpad_fast,
  output logic [1:0]       spinner,
  output logic             busy,
  output logic [POS_W-1:0] position
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  quad_t quad_q, quad_d;

  logic [PRE_W-1:0]        prescale;
  logic [DIV_W-1:0]        step_div;
  logic                    ce;
  logic                    step_tick;
  logic                    step_pend, step_pend_d;
  logic                    busy_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] mouse_ext, sum, sat_val;
  logic                    take_sum;
  logic                    load;
  logic signed [POS_W-1:0] load_val;

  // Negative position walks the code "forward", positive walks it in reverse.
  function automatic quad_t quad_fwd(input quad_t q);
    case (q)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

  function automatic quad_t quad_rev(input quad_t q);
    case (q)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

  assign ce        = (prescale == '0);
  assign step_tick = ce && (step_div == '0);

  always_ff @(posedge clk_48m or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      step_div <= '0;
    end else begin
      prescale <= (prescale == PRE_W'(CLK_DIV - 1)) ? '0 : prescale + PRE_W'(1);
      if (ce)
        step_div <= (step_div == DIV_W'(STEP_DIV - 1)) ? '0 : step_div + DIV_W'(1);
    end
  end

`ifdef SPINNER_DPAD_EN
  localparam int POLL_W = $clog2(POLL_TICKS + 1);

  logic [POLL_W-1:0] poll_cnt;
  logic              dpad_held;
  logic [POS_W-1:0]  dpad_mag;

  assign dpad_held = dpad_left || dpad_right;
  assign load      = ce && dpad_held && (poll_cnt == POLL_W'(POLL_TICKS - 1));
  assign dpad_mag  = dpad_fast ? POS_W'(FAST_STEP) : POS_W'(SLOW_STEP);
  assign load_val  = dpad_right ? dpad_mag : -dpad_mag;

  always_ff @(posedge clk_48m or negedge reset) begin
    if (!reset)
      poll_cnt <= '0;
    else if (!dpad_held)
      poll_cnt <= '0;
    else if (ce)
      poll_cnt <= load ? '0 : poll_cnt + POLL_W'(1);
  end
`else
  logic unused_dpad;

  assign unused_dpad = ^{dpad_left, dpad_right, dpad_fast};
  assign load        = 1'b0;
  assign load_val    = '0;
`endif

  always_comb begin
    mouse_ext   = POS_W'(signed'(mouse_x));
    sum         = pos_q + mouse_ext;
    take_sum    = (pos_q[POS_W-1] != mouse_x[8]) || (sum[POS_W-1] == pos_q[POS_W-1]);
    sat_val     = pos_q[POS_W-1] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    pos_d       = pos_q;
    quad_d      = quad_q;
    step_pend_d = step_pend;
    // A tick that loses to a load or strobe is replayed on the following cycle.
    if (load) begin
      pos_d       = load_val;
      step_pend_d = step_pend || step_tick;
    end else if (mouse_strobe) begin
      pos_d       = take_sum ? sum : sat_val;
      step_pend_d = step_pend || step_tick;
    end else if (step_tick || step_pend) begin
      step_pend_d = 1'b0;
      if (pos_q[POS_W-1]) begin
        pos_d  = pos_q + POS_W'(1);
        quad_d = quad_fwd(quad_q);
      end else if (pos_q != '0) begin
        pos_d  = pos_q - POS_W'(1);
        quad_d = quad_rev(quad_q);
      end
    end
    busy_d = (pos_d != '0);
  end

  always_ff @(posedge clk_48m or negedge reset) begin
    if (!reset) begin
      quad_q    <= Q00;
      pos_q     <= '0;
      busy      <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      quad_q    <= quad_d;
      pos_q     <= pos_d;
      busy      <= busy_d;
      step_pend <= step_pend_d;
    end
  end

  assign spinner  = quad_q;
  assign position = pos_q;

endmodule

// File: tb/tb_spinner_quad_emu.sv
// Directed bench for spinner_quad_emu: saturation vector table plus hand-written
// drain, coincidence, reset and D-pad sequences (shortened step/poll periods).
`timescale 1ns/1ps
module tb_spinner_quad_emu;

  localparam int STEP_DIV_TB = 50;
  localparam int SP          = 8 * STEP_DIV_TB;  // clocks per step tick
  localparam int POLL_TB     = 30;
  localparam int LOAD_CYC    = 1 + 8 * (POLL_TB - 1);

  logic        clk_48m = 1'b0;
  logic        reset = 1'b0;
  logic        mouse_strobe = 1'b0;
  logic [8:0]  mouse_x = '0;
  logic        dpad_left = 1'b0, dpad_right = 1'b0, dpad_fast = 1'b0;
  logic [1:0]  spinner;
  logic        busy;
  logic [11:0] position;

  int n_pass = 0;
  int n_total = 0;
  int ncyc = 0;

  always #5 clk_48m = ~clk_48m;

  spinner_quad_emu #(
    .CLK_DIV(8), .STEP_DIV(STEP_DIV_TB), .POLL_TICKS(POLL_TB),
    .SLOW_STEP(4), .FAST_STEP(9), .POS_W(12)
  ) dut (
    .clk_48m(clk_48m), .reset(reset), .mouse_strobe(mouse_strobe), .mouse_x(mouse_x),
    .dpad_left(dpad_left), .dpad_right(dpad_right), .dpad_fast(dpad_fast),
    .spinner(spinner), .busy(busy), .position(position)
  );

  typedef struct {
    int          pre;
    logic [8:0]  mx;
    logic [11:0] expect_pos;
  } sat_vec_t;

  sat_vec_t vecs [8];

  task automatic check(input string name, input logic [1:0] es, input logic eb, input logic [11:0] ep);
    n_total++;
    if ({spinner, busy, position} === {es, eb, ep}) n_pass++;
    else $display("FAIL %s: got spinner=%b busy=%b position=%h, want spinner=%b busy=%b position=%h",
                  name, spinner, busy, position, es, eb, ep);
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk_48m);
      #1;
      ncyc++;
    end
  endtask

  task automatic goto(input int n);
    if (n > ncyc) clocks(n - ncyc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mouse_strobe = 1'b0;
    dpad_left = 1'b0; dpad_right = 1'b0; dpad_fast = 1'b0;
    clocks(2);
    check("reset_state", 2'b00, 1'b0, 12'h000);
    reset = 1'b1;
    ncyc = 0;
  endtask

  task automatic strobe(input logic [8:0] v);
    mouse_strobe = 1'b1;
    mouse_x = v;
    clocks(1);
    mouse_strobe = 1'b0;
  endtask

  task automatic preload(input int target);
    int rem;
    rem = target;
    while (rem > 255) begin strobe(9'h0FF); rem -= 255; end
    while (rem < -256) begin strobe(9'h100); rem += 256; end
    if (rem != 0) strobe(9'(rem));
  endtask

  initial begin
    vecs[0] = '{2032,  9'h0FF, 12'h7FF};
    vecs[1] = '{-2048, 9'h1FF, 12'h800};
    vecs[2] = '{2047,  9'h1FB, 12'h7FA};
    vecs[3] = '{0,     9'h100, 12'hF00};
    vecs[4] = '{2047,  9'h001, 12'h7FF};
    vecs[5] = '{-2047, 9'h1FE, 12'h800};
    vecs[6] = '{16,    9'h1F0, 12'h000};
    vecs[7] = '{-2048, 9'h0FF, 12'h8FF};

    // Idle after reset
    do_reset();
    clocks(10000);
    check("idle", 2'b00, 1'b0, 12'h000);

    // +3 drains in reverse Gray order
    do_reset();
    clocks(1);
    strobe(9'h003);
    check("p3_load", 2'b00, 1'b1, 12'h003);
    goto(SP);
    check("p3_pre_tick", 2'b00, 1'b1, 12'h003);
    goto(SP + 1);
    check("p3_step1", 2'b10, 1'b1, 12'h002);
    goto(2 * SP + 1);
    check("p3_step2", 2'b11, 1'b1, 12'h001);
    goto(3 * SP + 1);
    check("p3_step3", 2'b01, 1'b0, 12'h000);
    goto(4 * SP + 1);
    check("p3_idle", 2'b01, 1'b0, 12'h000);

    // -2 drains in forward Gray order
    do_reset();
    clocks(1);
    strobe(9'h1FE);
    check("m2_load", 2'b00, 1'b1, 12'hFFE);
    goto(SP + 1);
    check("m2_step1", 2'b01, 1'b1, 12'hFFF);
    goto(2 * SP + 1);
    check("m2_step2", 2'b11, 1'b0, 12'h000);

    // Saturation table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clocks(1);
      preload(vecs[i].pre);
      check($sformatf("sat%0d_pre", i), 2'b00, vecs[i].pre != 0, 12'(vecs[i].pre));
      strobe(vecs[i].mx);
      check($sformatf("sat%0d_res", i), 2'b00, vecs[i].expect_pos != 12'h000, vecs[i].expect_pos);
    end

    // Strobe on a step-tick cycle: step deferred one cycle, applied to new position
    do_reset();
    clocks(1);
    strobe(9'h002);
    goto(SP);
    check("co_pre", 2'b00, 1'b1, 12'h002);
    strobe(9'h005);
    check("co_strobe", 2'b00, 1'b1, 12'h007);
    clocks(1);
    check("co_deferred", 2'b10, 1'b1, 12'h006);
    clocks(1);
    check("co_once", 2'b10, 1'b1, 12'h006);

    // Asynchronous reset mid-drain, then counting restarts from prescaler 0
    do_reset();
    clocks(1);
    strobe(9'h003);
    goto(SP + 1);
    check("rst_drain", 2'b10, 1'b1, 12'h002);
    #2 reset = 1'b0;
    #1 check("rst_async", 2'b00, 1'b0, 12'h000);
    do_reset();
    clocks(1);
    strobe(9'h001);
    goto(SP);
    check("rst_restart_pre", 2'b00, 1'b1, 12'h001);
    goto(SP + 1);
    check("rst_restart_step", 2'b10, 1'b0, 12'h000);

`ifdef SPINNER_DPAD_EN
    do_reset();
    dpad_right = 1'b1; dpad_fast = 1'b1;
    goto(LOAD_CYC - 1);
    check("dp_fast_pre", 2'b00, 1'b0, 12'h000);
    goto(LOAD_CYC);
    check("dp_fast", 2'b00, 1'b1, 12'h009);

    do_reset();
    dpad_left = 1'b1;
    goto(LOAD_CYC);
    check("dp_left", 2'b00, 1'b1, 12'hFFC);

    do_reset();
    dpad_left = 1'b1; dpad_right = 1'b1;
    goto(LOAD_CYC);
    check("dp_both", 2'b00, 1'b1, 12'h004);

    do_reset();
    dpad_right = 1'b1;
    goto(LOAD_CYC - 1);
    strobe(9'h050);
    check("dp_strobe_drop", 2'b00, 1'b1, 12'h004);
    clocks(1);
    check("dp_strobe_after", 2'b00, 1'b1, 12'h004);
`else
    do_reset();
    dpad_right = 1'b1; dpad_fast = 1'b1;
    goto(LOAD_CYC + 8);
    check("dp_ignored", 2'b00, 1'b0, 12'h000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
